// File: rtl/spike_readout_argmax.sv
// spike_readout_argmax: counts SNN timesteps per inference window, snapshots the
// per-neuron spike counts when the window closes, scans them one lane per cycle
// for the argmax, and returns the winner over a valid/ready handshake.
module spike_readout_argmax #(
  parameter int NUM_NEURONS = 2,
  parameter int TIMER_WIDTH = 5,
  parameter int NUM_STEPS   = 16,
  parameter int IDX_WIDTH   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               step_valid,
  input  logic [NUM_NEURONS*TIMER_WIDTH-1:0] accumulated_spikes,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [IDX_WIDTH-1:0]               out_class,
  output logic [TIMER_WIDTH-1:0]             out_count,
  output logic                               window_done,
  output logic                               busy,
  output logic                               step_dropped
);

  typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_e;

  localparam logic [15:0]          LAST_STEP = 16'(NUM_STEPS - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);

  // Lane i of the packed input sits at [i*TIMER_WIDTH +: TIMER_WIDTH].
  logic [NUM_NEURONS-1:0][TIMER_WIDTH-1:0] lanes;
  assign lanes = accumulated_spikes;

  state_e                                  state_q, state_d;
  logic [15:0]                             step_cnt_q, step_cnt_d;
  logic [IDX_WIDTH-1:0]                    idx_q, idx_d;
  logic [NUM_NEURONS-1:0][TIMER_WIDTH-1:0] snap_q, snap_d;
  logic [TIMER_WIDTH-1:0]                  best_cnt_q, best_cnt_d;
  logic [IDX_WIDTH-1:0]                    best_idx_q, best_idx_d;
  logic                                    out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0]                    out_class_q, out_class_d;
  logic [TIMER_WIDTH-1:0]                  out_count_q, out_count_d;
  logic                                    window_done_q, window_done_d;
  logic                                    step_dropped_q, step_dropped_d;

  // Running best including the lane under scan; strict compare keeps the lower index on ties.
  logic [TIMER_WIDTH-1:0] cur_cnt, nb_cnt;
  logic [IDX_WIDTH-1:0]   nb_idx;
  logic                   better;

  // Scan comparator: current snapshot lane against the best seen so far.
  always_comb begin
    cur_cnt = snap_q[idx_q];
    better  = cur_cnt > best_cnt_q;
    nb_cnt  = better ? cur_cnt : best_cnt_q;
    nb_idx  = better ? idx_q   : best_idx_q;
  end

  // Next-state logic for the ACCUM -> SCAN -> DONE window cycle.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    idx_d          = idx_q;
    snap_d         = snap_q;
    best_cnt_d     = best_cnt_q;
    best_idx_d     = best_idx_q;
    out_valid_d    = out_valid_q;
    out_class_d    = out_class_q;
    out_count_d    = out_count_q;
    window_done_d  = 1'b0;
    step_dropped_d = step_dropped_q;

    // Steps arriving outside ACCUM are never counted, only flagged.
    if (step_valid && (state_q != ACCUM)) step_dropped_d = 1'b1;

    unique case (state_q)
      ACCUM: begin
        if (step_valid) begin
          if (step_cnt_q == LAST_STEP) begin
            // Closing step: counts on this cycle already include it.
            snap_d        = lanes;
            step_cnt_d    = '0;
            idx_d         = '0;
            best_cnt_d    = '0;
            best_idx_d    = '0;
            window_done_d = 1'b1;
            state_d       = SCAN;
          end else begin
            step_cnt_d = step_cnt_q + 16'd1;
          end
        end
      end
      SCAN: begin
        best_cnt_d = nb_cnt;
        best_idx_d = nb_idx;
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
          out_class_d = nb_idx;
          out_count_d = nb_cnt;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers; reset aborts any window in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ACCUM;
      step_cnt_q     <= '0;
      idx_q          <= '0;
      snap_q         <= '0;
      best_cnt_q     <= '0;
      best_idx_q     <= '0;
      out_valid_q    <= 1'b0;
      out_class_q    <= '0;
      out_count_q    <= '0;
      window_done_q  <= 1'b0;
      step_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      best_cnt_q     <= best_cnt_d;
      best_idx_q     <= best_idx_d;
      out_valid_q    <= out_valid_d;
      out_class_q    <= out_class_d;
      out_count_q    <= out_count_d;
      window_done_q  <= window_done_d;
      step_dropped_q <= step_dropped_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_class    = out_class_q;
  assign out_count    = out_count_q;
  assign window_done  = window_done_q;
  assign step_dropped = step_dropped_q;
  assign busy         = (state_q != ACCUM);

endmodule

// File: tb/tb_spike_readout_argmax.sv
// Directed bench for spike_readout_argmax: a 2-lane instance for most scenarios
// and a 4-lane instance for the width/latency case.
module tb_spike_readout_argmax;

  logic       clk = 1'b0;
  logic       rst;
  // 2-lane instance
  logic       step_valid, out_ready;
  logic [9:0] acc;
  logic       out_valid, window_done, busy, step_dropped;
  logic [0:0] out_class;
  logic [4:0] out_count;
  // 4-lane instance
  logic        step_valid2, out_ready2;
  logic [19:0] acc2;
  logic        out_valid2, window_done2, busy2, step_dropped2;
  logic [1:0]  out_class2;
  logic [4:0]  out_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_readout_argmax #(.NUM_NEURONS(2), .TIMER_WIDTH(5), .NUM_STEPS(4), .IDX_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .accumulated_spikes(acc),
    .out_ready(out_ready), .out_valid(out_valid), .out_class(out_class),
    .out_count(out_count), .window_done(window_done), .busy(busy),
    .step_dropped(step_dropped));

  spike_readout_argmax #(.NUM_NEURONS(4), .TIMER_WIDTH(5), .NUM_STEPS(4), .IDX_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .step_valid(step_valid2), .accumulated_spikes(acc2),
    .out_ready(out_ready2), .out_valid(out_valid2), .out_class(out_class2),
    .out_count(out_count2), .window_done(window_done2), .busy(busy2),
    .step_dropped(step_dropped2));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [4:0] c0, input logic [4:0] c1);
    step_valid = 1'b1; acc = {c1, c0};
    cyc();
    step_valid = 1'b0;
  endtask

  // Four accepted steps; the last carries the closing counts. Returns just after the closing edge.
  task automatic close_window(input logic [4:0] c0, input logic [4:0] c1);
    step(5'd0, 5'd0); step(5'd0, 5'd0); step(5'd0, 5'd0);
    step(c0, c1);
  endtask

  task automatic handshake();
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step_valid = 0; out_ready = 0; acc = '0;
    step_valid2 = 0; out_ready2 = 0; acc2 = '0;
    cyc(); cyc();
    checks++;
    if ({out_valid, out_class, out_count, window_done, busy, step_dropped} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0",
        {out_valid, out_class, out_count, window_done, busy, step_dropped});
    end
    @(negedge clk); rst = 1'b0; cyc();
  endtask

  task automatic test_basic();
    step(5'd0, 5'd0); step(5'd0, 5'd0); step(5'd0, 5'd0);
    checks++;
    if (window_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_early_close: window_done=%b busy=%b want 0 0", window_done, busy);
    end
    step(5'd3, 5'd7);
    checks++;
    if (window_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_close: wd=%b ov=%b busy=%b want 1 0 1", window_done, out_valid, busy);
    end
    cyc();
    checks++;
    if (window_done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_scan: wd=%b ov=%b want 0 0", window_done, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd1 || out_count !== 5'd7) begin
      errors++; $display("FAIL basic_result: ov=%b class=%0d count=%0d want 1 1 7", out_valid, out_class, out_count);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_accept: ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_tie_zero();
    close_window(5'd5, 5'd5); cyc(); cyc();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd0 || out_count !== 5'd5) begin
      errors++; $display("FAIL tie: ov=%b class=%0d count=%0d want 1 0 5", out_valid, out_class, out_count);
    end
    handshake();
    close_window(5'd0, 5'd0); cyc(); cyc();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd0 || out_count !== 5'd0) begin
      errors++; $display("FAIL zero: ov=%b class=%0d count=%0d want 1 0 0", out_valid, out_class, out_count);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    close_window(5'd1, 5'd4); cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_class !== 1'd1 || out_count !== 5'd4) begin
        errors++; $display("FAIL backpressure_hold[%0d]: ov=%b class=%0d count=%0d want 1 1 4",
          i, out_valid, out_class, out_count);
      end
      cyc();
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_busy_drop();
    close_window(5'd2, 5'd6);
    checks++;
    if (step_dropped !== 1'b0) begin
      errors++; $display("FAIL drop_initial: step_dropped=%b want 0", step_dropped);
    end
    step_valid = 1'b1; cyc(); step_valid = 1'b0;   // during SCAN
    checks++;
    if (step_dropped !== 1'b1) begin
      errors++; $display("FAIL drop_scan: step_dropped=%b want 1", step_dropped);
    end
    cyc();
    step_valid = 1'b1; cyc(); step_valid = 1'b0;   // during DONE, no ready
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd1 || out_count !== 5'd6) begin
      errors++; $display("FAIL drop_result: ov=%b class=%0d count=%0d want 1 1 6", out_valid, out_class, out_count);
    end
    // step_valid coincident with the accepting handshake is also dropped
    out_ready = 1'b1; step_valid = 1'b1; cyc(); step_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drop_accept: busy=%b ov=%b want 0 0", busy, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(5'd8, 5'd1);
      checks++;
      if (window_done !== 1'b0) begin
        errors++; $display("FAIL drop_stepcount[%0d]: window_done=%b want 0", i, window_done);
      end
    end
    step(5'd8, 5'd1);
    checks++;
    if (window_done !== 1'b1) begin
      errors++; $display("FAIL drop_fourth_step: window_done=%b want 1", window_done);
    end
    cyc(); cyc();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd0 || out_count !== 5'd8 || step_dropped !== 1'b1) begin
      errors++; $display("FAIL drop_next_window: ov=%b class=%0d count=%0d sd=%b want 1 0 8 1",
        out_valid, out_class, out_count, step_dropped);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    close_window(5'd7, 5'd1); cyc();   // mid-SCAN
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_class, out_count, window_done, busy, step_dropped} !== 10'd0) begin
      errors++; $display("FAIL reset_mid_async: got %b want 0",
        {out_valid, out_class, out_count, window_done, busy, step_dropped});
    end
    @(negedge clk); rst = 1'b0; cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || window_done !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet[%0d]: ov=%b wd=%b want 0 0", i, out_valid, window_done);
      end
      cyc();
    end
    close_window(5'd9, 5'd2); cyc(); cyc();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 1'd0 || out_count !== 5'd9) begin
      errors++; $display("FAIL reset_mid_next: ov=%b class=%0d count=%0d want 1 0 9", out_valid, out_class, out_count);
    end
    handshake();
  endtask

  task automatic test_width();
    // lane0=31, lane1=30, lane2=31, lane3=31
    for (int i = 0; i < 4; i++) begin
      step_valid2 = 1'b1;
      acc2 = (i == 3) ? {5'd31, 5'd31, 5'd30, 5'd31} : 20'd0;
      cyc();
    end
    step_valid2 = 1'b0;
    checks++;
    if (window_done2 !== 1'b1) begin
      errors++; $display("FAIL width_close: window_done=%b want 1", window_done2);
    end
    for (int i = 1; i < 4; i++) begin
      cyc();
      checks++;
      if (out_valid2 !== 1'b0) begin
        errors++; $display("FAIL width_latency[%0d]: ov=%b want 0", i, out_valid2);
      end
    end
    cyc();
    checks++;
    if (out_valid2 !== 1'b1 || out_class2 !== 2'd0 || out_count2 !== 5'd31) begin
      errors++; $display("FAIL width_result: ov=%b class=%0d count=%0d want 1 0 31", out_valid2, out_class2, out_count2);
    end
    out_ready2 = 1'b1; cyc(); out_ready2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL width_accept: ov=%b busy=%b want 0 0", out_valid2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_zero();
    test_backpressure();
    test_busy_drop();
    test_reset_mid();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
